// File: rtl/rx_control.sv
`default_nettype none
// ============================================================================
// Module  : rx_control
// Desc    : JESD204B receive link control - CGS, SYNC~ generation, ILA
//           tracking and user-data gating. Optional macro
//           RX_SYNC_ERR_REPORT_EN adds SYNC~ error reporting in DATA.
// Rev     : 1.0 - initial release
// ============================================================================
module rx_control #(
  parameter int K_CNT_MIN  = 4,
  parameter int ERR_THRESH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_clk,
  input  logic       lmfc_clk,
  input  logic       i_link_reset,
  input  logic [7:0] i_octet,
  input  logic       i_is_k,
  input  logic       i_code_err,
  input  logic [7:0] i_ila_multiframe_length,
  output logic       o_sync_n,
  output logic [1:0] o_rx_state,
  output logic       o_ila_active,
  output logic       o_data_valid
);

  typedef enum logic [1:0] {
    CGS_INIT  = 2'd0,
    CGS_CHECK = 2'd1,
    ILA       = 2'd2,
    DATA      = 2'd3
  } state_t;

  localparam logic [2:0] c_k_last   = 3'(K_CNT_MIN - 1);
  localparam logic [1:0] c_err_last = 2'(ERR_THRESH - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_k_cnt;
  logic [1:0] r_err_cnt;
  logic [8:0] r_mf_cnt;
  logic       r_sync_ok;
  logic       w_is_k;
  logic       w_is_r;
  logic       w_is_a;
  logic [8:0] w_len_p1;
  logic       w_sync_n_next;
  logic       w_data_sync_n;

  // A code error disqualifies the octet from being any control character
  assign w_is_k   = i_is_k & ~i_code_err & (i_octet == 8'hBC);
  assign w_is_r   = i_is_k & ~i_code_err & (i_octet == 8'h1C);
  assign w_is_a   = i_is_k & ~i_code_err & (i_octet == 8'h7C);
  assign w_len_p1 = {1'b0, i_ila_multiframe_length} + 9'd1;

  always_comb begin
    w_next_state = r_state;
    if (i_link_reset) begin
      w_next_state = CGS_INIT;
    end else if ((r_state != CGS_INIT) && i_code_err && (r_err_cnt == c_err_last)) begin
      w_next_state = CGS_INIT;
    end else begin
      case (r_state)
        CGS_INIT: begin
          if (w_is_k && (r_k_cnt == c_k_last)) w_next_state = CGS_CHECK;
        end
        CGS_CHECK: begin
          if (r_sync_ok && w_is_r) w_next_state = ILA;
        end
        ILA: begin
          if (w_is_k) begin
            w_next_state = CGS_INIT;
          end else if (w_is_a && ((r_mf_cnt + 9'd1) == w_len_p1)) begin
            w_next_state = DATA;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

`ifdef RX_SYNC_ERR_REPORT_EN
  logic r_rpt;
  logic r_rpt_half;
  logic w_rpt_next;
  logic w_rpt_half_next;

  // Report window closes on the second frame_clk pulse after the error octet
  always_comb begin
    w_rpt_next      = 1'b0;
    w_rpt_half_next = 1'b0;
    if ((r_state == DATA) && (w_next_state == DATA)) begin
      if (r_rpt) begin
        w_rpt_next      = ~(frame_clk & r_rpt_half);
        w_rpt_half_next = r_rpt_half | frame_clk;
      end else if (i_code_err) begin
        w_rpt_next = 1'b1;
      end
    end
  end

  assign w_data_sync_n = ~w_rpt_next;
`else
  logic w_unused_frame;
  assign w_unused_frame = frame_clk;
  assign w_data_sync_n  = 1'b1;
`endif

  always_comb begin
    case (w_next_state)
      CGS_CHECK: w_sync_n_next = (r_state == CGS_CHECK) & (r_sync_ok | lmfc_clk);
      ILA:       w_sync_n_next = 1'b1;
      DATA:      w_sync_n_next = w_data_sync_n;
      default:   w_sync_n_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CGS_INIT;
      r_k_cnt      <= 3'd0;
      r_err_cnt    <= 2'd0;
      r_mf_cnt     <= 9'd0;
      r_sync_ok    <= 1'b0;
      o_sync_n     <= 1'b0;
      o_rx_state   <= 2'd0;
      o_ila_active <= 1'b0;
      o_data_valid <= 1'b0;
`ifdef RX_SYNC_ERR_REPORT_EN
      r_rpt        <= 1'b0;
      r_rpt_half   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;

      if (i_link_reset || (r_state != CGS_INIT) || (w_next_state != CGS_INIT)) begin
        r_k_cnt <= 3'd0;
      end else if (w_is_k) begin
        r_k_cnt <= (r_k_cnt == 3'd7) ? 3'd7 : r_k_cnt + 3'd1;
      end else begin
        r_k_cnt <= 3'd0;
      end

      if ((r_state == CGS_INIT) || (w_next_state == CGS_INIT)) begin
        r_err_cnt <= 2'd0;
      end else if (i_code_err) begin
        r_err_cnt <= r_err_cnt + 2'd1;
      end else begin
        r_err_cnt <= 2'd0;
      end

      if ((r_state != ILA) || (w_next_state != ILA)) begin
        r_mf_cnt <= 9'd0;
      end else if (w_is_a) begin
        r_mf_cnt <= r_mf_cnt + 9'd1;
      end

      if ((r_state != CGS_CHECK) || (w_next_state != CGS_CHECK)) begin
        r_sync_ok <= 1'b0;
      end else if (lmfc_clk) begin
        r_sync_ok <= 1'b1;
      end

`ifdef RX_SYNC_ERR_REPORT_EN
      r_rpt      <= w_rpt_next;
      r_rpt_half <= w_rpt_half_next;
`endif

      o_sync_n     <= w_sync_n_next;
      o_rx_state   <= w_next_state;
      o_ila_active <= (w_next_state == ILA);
      o_data_valid <= (w_next_state == DATA);
    end
  end

endmodule
`default_nettype wire

// File: doc/rx_control.md
Name: rx_control

Overview:
- JESD204B receive-side link control FSM. It is the counterpart of the TX link controller.
- Consumes the decoded octet stream from the 8b/10b decoder, one octet per clk.
- Performs code group synchronisation (CGS) and drives SYNC~ back to the transmitter.
- Tracks the initial lane alignment (ILA) sequence and gates user data to the deframer once ILA completes.

Parameters:
- K_CNT_MIN, 4, consecutive valid /K/ (K28.5) octets required to pass CGS_INIT.
- ERR_THRESH, 3, consecutive code-error octets that force a return to CGS_INIT.

Ports:
- clk  input  1  device clock
- rst_n  input  1  asynchronous active-low reset
- frame_clk  input  1  single-clk frame boundary pulse
- lmfc_clk  input  1  single-clk LMFC boundary pulse
- i_link_reset  input  1  synchronous request to restart link synchronisation
- i_octet  input  8  decoded octet
- i_is_k  input  1  i_octet is a control character
- i_code_err  input  1  disparity or not-in-table error on this octet
- i_ila_multiframe_length  input  8  ILA length in multiframes, 1~256, encoded as value-1
- o_sync_n  output  1  SYNC~ to transmitter, active low
- o_rx_state  output  2  0 CGS_INIT, 1 CGS_CHECK, 2 ILA, 3 DATA
- o_ila_active  output  1  high while in ILA
- o_data_valid  output  1  high while in DATA; qualifies i_octet for the deframer

Behaviour:
- Character decode:
  - /K/ = i_is_k & i_octet==8'hBC.
  - /R/ = i_is_k & i_octet==8'h1C.
  - /A/ = i_is_k & i_octet==8'h7C.
  - Any octet with i_code_err=1 is never /K/, /R/ or /A/.
- Reset values: state CGS_INIT, o_sync_n=0, o_rx_state=0, o_ila_active=0, o_data_valid=0, all counters 0.
- Outputs are registered and decoded from next_state, so they change on the same edge the state changes.
- i_link_reset=1 forces CGS_INIT on the next edge from any state and overrides every other transition.
- CGS_INIT:
  - o_sync_n=0.
  - k_cnt (3 bits, saturating) increments on /K/ and clears on any other octet.
  - When k_cnt==K_CNT_MIN-1 and the current octet is /K/, go to CGS_CHECK.
- CGS_CHECK:
  - o_sync_n stays 0 until the first lmfc_clk pulse seen in this state.
  - From that same edge o_sync_n=1; it is held until the state leaves.
  - With o_sync_n=1 and /R/ received, go to ILA. /R/ received while o_sync_n=0 is ignored; stay.
  - /K/ octets keep the state.
- ILA:
  - o_ila_active=1.
  - The /R/ that caused entry counts as the start of multiframe 1.
  - ila_mf_cnt (9 bits) increments on each /A/; it is cleared on entry.
  - When ila_mf_cnt+1 == i_ila_multiframe_length+1 on an /A/ octet, go to DATA on that edge.
  - /K/ received in ILA means the transmitter restarted: go to CGS_INIT.
- DATA: o_data_valid=1; /A/ and /K/ octets are passed with o_data_valid=1 (character replacement is undone downstream).
- Error counting (CGS_CHECK, ILA, DATA):
  - err_cnt (2 bits) increments on i_code_err=1 and clears on any error-free octet.
  - When err_cnt==ERR_THRESH-1 and i_code_err=1, go to CGS_INIT.
  - In CGS_INIT, err_cnt is held at 0.
- Simultaneous events:
  - Error-threshold exit takes priority over the /R/ or final /A/ transition on the same octet.
  - lmfc_clk and /R/ on the same octet in CGS_CHECK: o_sync_n goes 1 on that edge, but the /R/ is ignored (SYNC~ was still 0 when it arrived).
- Width:
  - i_ila_multiframe_length+1 is computed in 9 bits, so 8'hFF gives 256 multiframes.
  - ila_mf_cnt never wraps before the exit condition.

Optional Feature:
- Macro: RX_SYNC_ERR_REPORT_EN.
- Defined:
  - In DATA, a single code error that does not reach the threshold drives o_sync_n low for exactly 2 frame_clk periods as an error report to the transmitter.
  - The low period starts on the edge after the error octet and ends on the edge of the 2nd subsequent frame_clk pulse.
  - The state stays DATA.
  - A new error during an active report does not extend it.
  - Threshold exit overrides the report; o_sync_n is then 0 from CGS_INIT.
- Undefined: o_sync_n is always 1 in DATA.

Test Plan:
- Reset, then 4 consecutive /K/:
  - o_rx_state 0→1 on the 4th /K/ edge; o_sync_n=0.
  - Next lmfc_clk: o_sync_n=1.
- 3 /K/, then 8'h00 (i_is_k=0), then 3 /K/ → remains CGS_INIT; k_cnt restarts from 0.
- CGS done, o_sync_n=1, i_ila_multiframe_length=8'h03:
  - Send /R/ → o_rx_state=2, o_ila_active=1.
  - After the 4th /A/ → o_rx_state=3, o_data_valid=1.
- In DATA:
  - 2 error octets then 1 clean octet → stays in DATA.
  - Then 3 consecutive error octets → CGS_INIT on the 3rd; o_sync_n=0, o_data_valid=0.
- In ILA after 2 /A/, assert i_link_reset for 1 clk → CGS_INIT, o_ila_active=0; a fresh CGS is required to re-enter CGS_CHECK.
- RX_SYNC_ERR_REPORT_EN defined, in DATA with one error octet:
  - o_sync_n low for 2 frame_clk periods, then 1.
  - o_rx_state stays 3.
